// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one main-memory port between the I-cache refill
// engine and the D-cache refill/write-back engine. One requester is granted
// at a time and runs a fixed line burst of BURST_LEN word beats.
// Optional feature macro: MEM_ARB_CRITICAL_WORD_FIRST_EN
//   defined   -> refill bursts start at the missed word and wrap in the line
//   undefined -> every burst starts at word 0 of the line
module mem_refill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_req_i,
  input  logic [ADDR_WIDTH-1:0]        ic_addr_i,
  output logic [DATA_WIDTH-1:0]        ic_rdata_o,
  output logic                         ic_rvalid_o,
  output logic [$clog2(BURST_LEN)-1:0] ic_beat_o,
  output logic                         ic_done_o,
  input  logic                         dc_req_i,
  input  logic                         dc_we_i,
  input  logic [ADDR_WIDTH-1:0]        dc_addr_i,
  input  logic [DATA_WIDTH-1:0]        dc_wdata_i,
  output logic [DATA_WIDTH-1:0]        dc_rdata_o,
  output logic                         dc_rvalid_o,
  output logic                         dc_wready_o,
  output logic [$clog2(BURST_LEN)-1:0] dc_beat_o,
  output logic                         dc_done_o,
  output logic                         mem_valid_o,
  output logic                         mem_we_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  input  logic                         mem_ready_i,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
  output logic                         busy_o
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
  localparam int LINE_SH = BEAT_W + BYTE_SH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  state_t                  r_state;
  owner_t                  r_owner;
  owner_t                  r_lastGrant;
  logic [BEAT_W-1:0]       r_beat;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic                    r_we;

  logic                    w_reqAny;
  logic                    w_grantDc;
  owner_t                  w_grantOwner;
  logic [ADDR_WIDTH-1:0]   w_icBase;
  logic [ADDR_WIDTH-1:0]   w_dcBase;
  logic [BEAT_W-1:0]       w_wordIdx;
  logic                    w_inBurst;
  logic                    w_ownerDc;
  logic                    w_unusedLowBits;

  // Arbitration: a lone requester wins, a tie goes to whoever did not win last.
  assign w_reqAny     = ic_req_i | dc_req_i;
  assign w_grantDc    = dc_req_i & (~ic_req_i | (r_lastGrant == OWN_IC));
  assign w_grantOwner = w_grantDc ? OWN_DC : OWN_IC;

  // Line base addresses: clear the word and byte offset within the line.
  assign w_icBase = {ic_addr_i[ADDR_WIDTH-1:LINE_SH], {LINE_SH{1'b0}}};
  assign w_dcBase = {dc_addr_i[ADDR_WIDTH-1:LINE_SH], {LINE_SH{1'b0}}};

  // The in-line offset bits only matter for the critical-word start index.
  assign w_unusedLowBits = ^{ic_addr_i[LINE_SH-1:0], dc_addr_i[LINE_SH-1:0]};

  assign w_inBurst = (r_state == BURST);
  assign w_ownerDc = (r_owner == OWN_DC);
  assign busy_o    = (r_state != IDLE);

  // Main FSM: grant in IDLE, count completed beats in BURST, one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IC;
      r_lastGrant <= OWN_IC;
      r_beat      <= '0;
      r_base      <= '0;
      r_we        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_reqAny) begin
            r_state     <= BURST;
            r_owner     <= w_grantOwner;
            r_lastGrant <= w_grantOwner;
            r_beat      <= '0;
            r_base      <= w_grantDc ? w_dcBase : w_icBase;
            r_we        <= w_grantDc & dc_we_i;
          end
        end
        BURST: begin
          if (mem_ready_i) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_CRITICAL_WORD_FIRST_EN
  logic [BEAT_W-1:0] r_start;

  // Capture the missed word as the burst start; write-backs always start at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= '0;
    end else if ((r_state == IDLE) && w_reqAny) begin
      if (w_grantDc) begin
        r_start <= dc_we_i ? '0 : dc_addr_i[LINE_SH-1:BYTE_SH];
      end else begin
        r_start <= ic_addr_i[LINE_SH-1:BYTE_SH];
      end
    end
  end

  assign w_wordIdx = r_start + r_beat;
`else
  assign w_wordIdx = r_beat;
`endif

  // Output decode: memory beat request, per-owner data handshakes and done.
  always_comb begin
    ic_rdata_o  = '0;
    ic_rvalid_o = 1'b0;
    ic_beat_o   = '0;
    ic_done_o   = 1'b0;
    dc_rdata_o  = '0;
    dc_rvalid_o = 1'b0;
    dc_wready_o = 1'b0;
    dc_beat_o   = '0;
    dc_done_o   = 1'b0;
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_inBurst) begin
      mem_valid_o = 1'b1;
      mem_we_o    = r_we;
      mem_addr_o  = r_base + (ADDR_WIDTH'(w_wordIdx) << BYTE_SH);
      mem_wdata_o = r_we ? dc_wdata_i : '0;
      if (w_ownerDc) begin
        dc_beat_o = w_wordIdx;
      end else begin
        ic_beat_o = w_wordIdx;
      end
      if (mem_ready_i) begin
        if (w_ownerDc) begin
          if (r_we) begin
            dc_wready_o = 1'b1;
          end else begin
            dc_rvalid_o = 1'b1;
            dc_rdata_o  = mem_rdata_i;
          end
        end else begin
          ic_rvalid_o = 1'b1;
          ic_rdata_o  = mem_rdata_i;
        end
      end
    end
    if (r_state == DONE) begin
      if (w_ownerDc) begin
        dc_done_o = 1'b1;
      end else begin
        ic_done_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Testbench for mem_refill_arbiter. Directed scenes followed by randomized
// traffic; a behavioural model predicts every burst at grant time and a
// negedge monitor compares the DUT's beats and done pulses against it.
module tb_mem_refill_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BL         = 4;
  localparam int BW         = $clog2(BL);
  localparam int WORD_BYTES = DW / 8;
  localparam int LINE_BYTES = BL * WORD_BYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_i;
  logic [AW-1:0] ic_addr_i;
  logic [DW-1:0] ic_rdata_o;
  logic          ic_rvalid_o;
  logic [BW-1:0] ic_beat_o;
  logic          ic_done_o;
  logic          dc_req_i;
  logic          dc_we_i;
  logic [AW-1:0] dc_addr_i;
  logic [DW-1:0] dc_wdata_i;
  logic [DW-1:0] dc_rdata_o;
  logic          dc_rvalid_o;
  logic          dc_wready_o;
  logic [BW-1:0] dc_beat_o;
  logic          dc_done_o;
  logic          mem_valid_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ready_i;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o;

  mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_beat_o(ic_beat_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_rdata_o(dc_rdata_o), .dc_rvalid_o(dc_rvalid_o),
    .dc_wready_o(dc_wready_o), .dc_beat_o(dc_beat_o), .dc_done_o(dc_done_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            isDc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            idx;
  } beat_t;

  beat_t expQ[$];
  bit    doneQ[$];
  bit    readyPat[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the memory port: who holds it and how many beats remain.
  bit mActive;
  int mBeatsLeft;
  bit mDoneCycle;
  bit mOwnerDc;
  bit mLastDc;
  bit mJustReset;

  bit            icPending;
  bit            dcPending;
  bit            icRelease;
  bit            dcRelease;
  logic [DW-1:0] dcSeed;
  int            pIcReq;
  int            pDcReq;
  int            pReady;
  int            pDrop;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [DW-1:0] wbWord(input logic [DW-1:0] seed, input int idx);
    return seed ^ (32'h01010101 * 32'(idx));
  endfunction

  assign mem_rdata_i = memWord(mem_addr_o);
  assign dc_wdata_i  = wbWord(dcSeed, int'(dc_beat_o));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got no entry, expected one at %0t", name, $time);
  endtask

  // Grant-time prediction: the whole burst is laid out from the line arithmetic.
  function automatic void issueTransaction(input bit isDc);
    logic [AW-1:0] a;
    logic [AW-1:0] base;
    bit            we;
    int            offset;
    int            start;
    beat_t         e;
    a      = isDc ? dc_addr_i : ic_addr_i;
    we     = isDc && dc_we_i;
    offset = int'(a % LINE_BYTES);
    base   = a - AW'(offset);
    start  = 0;
`ifdef MEM_ARB_CRITICAL_WORD_FIRST_EN
    if (!we) start = offset / WORD_BYTES;
`endif
    for (int b = 0; b < BL; b++) begin
      e.isDc = isDc;
      e.we   = we;
      e.idx  = (start + b) % BL;
      e.addr = base + AW'(e.idx * WORD_BYTES);
      e.data = we ? wbWord(dcSeed, e.idx) : memWord(e.addr);
      expQ.push_back(e);
    end
    doneQ.push_back(isDc);
    mActive    = 1'b1;
    mBeatsLeft = BL;
    mDoneCycle = 1'b0;
    mOwnerDc   = isDc;
    mLastDc    = isDc;
  endfunction

  // Advance the model by the clock edge that just happened.
  function automatic void modelUpdate();
    mJustReset = rst;
    icRelease  = 1'b0;
    dcRelease  = 1'b0;
    if (rst) begin
      expQ.delete();
      doneQ.delete();
      mActive    = 1'b0;
      mBeatsLeft = 0;
      mDoneCycle = 1'b0;
      mLastDc    = 1'b0;
      icPending  = ic_req_i;
      dcPending  = dc_req_i;
    end else if (mDoneCycle) begin
      mDoneCycle = 1'b0;
      mActive    = 1'b0;
      if (mOwnerDc) dcRelease = 1'b1;
      else          icRelease = 1'b1;
    end else if (mActive) begin
      if (mem_ready_i) begin
        mBeatsLeft--;
        if (mBeatsLeft == 0) mDoneCycle = 1'b1;
      end
    end else if (ic_req_i || dc_req_i) begin
      issueTransaction(dc_req_i && (!ic_req_i || !mLastDc));
    end
  endfunction

  task automatic raiseIc(input logic [AW-1:0] addr);
    ic_req_i  = 1'b1;
    ic_addr_i = addr;
    icPending = 1'b1;
  endtask

  task automatic raiseDc(input logic [AW-1:0] addr, input bit we);
    dc_req_i  = 1'b1;
    dc_addr_i = addr;
    dc_we_i   = we;
    dcSeed    = $urandom;
    dcPending = 1'b1;
  endtask

  // Requester and memory behaviour for the cycle after the edge.
  task automatic driveInputs();
    if (readyPat.size() > 0) mem_ready_i = readyPat.pop_front();
    else                     mem_ready_i = ($urandom_range(0, 99) < pReady);
    if (icRelease) begin
      ic_req_i  = 1'b0;
      icPending = 1'b0;
    end else if (icPending && mActive && !mOwnerDc && mBeatsLeft > 0 && $urandom_range(0, 99) < pDrop) begin
      ic_req_i = 1'b0;
    end
    if (!icPending && $urandom_range(0, 99) < pIcReq) raiseIc($urandom);
    if (dcRelease) begin
      dc_req_i  = 1'b0;
      dcPending = 1'b0;
    end else if (dcPending && mActive && mOwnerDc && mBeatsLeft > 0 && $urandom_range(0, 99) < pDrop) begin
      dc_req_i = 1'b0;
    end
    if (!dcPending && $urandom_range(0, 99) < pDcReq) raiseDc($urandom, bit'($urandom_range(0, 1)));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    #1;
    driveInputs();
  endtask

  task automatic waitQuiet(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (!mActive && !icPending && !dcPending) return;
      applyStimulus();
    end
    if (mActive || icPending || dcPending) reportFail("quietTimeout");
  endtask

  // Monitor: compare DUT outputs against the model and pop the scoreboard.
  always @(negedge clk) begin : monitor
    beat_t e;
    bit    inBurst;
    bit    dutBeat;
    bit    doneOwner;
    inBurst = mActive && (mBeatsLeft > 0);
    dutBeat = ic_rvalid_o || dc_rvalid_o || dc_wready_o;
    checkOutput("busy", 64'(busy_o), 64'(mActive));
    checkOutput("memValid", 64'(mem_valid_o), 64'(inBurst));
    checkOutput("icDone", 64'(ic_done_o), 64'(mDoneCycle && !mOwnerDc));
    checkOutput("dcDone", 64'(dc_done_o), 64'(mDoneCycle && mOwnerDc));
    checkOutput("beatEvent", 64'(dutBeat), 64'(inBurst && mem_ready_i));
    if (mJustReset) begin
      checkOutput("resetOutputs", 64'(|{ic_rdata_o, ic_rvalid_o, ic_beat_o, ic_done_o,
                  dc_rdata_o, dc_rvalid_o, dc_wready_o, dc_beat_o, dc_done_o,
                  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o}), 64'(0));
    end
    if (ic_done_o || dc_done_o) begin
      if (doneQ.size() == 0) begin
        reportFail("doneQueue");
      end else begin
        doneOwner = doneQ.pop_front();
        checkOutput("doneOwner", 64'(dc_done_o), 64'(doneOwner));
      end
    end
    if (inBurst && expQ.size() > 0) begin
      e = expQ[0];
      checkOutput("memAddr", 64'(mem_addr_o), 64'(e.addr));
      checkOutput("memWe", 64'(mem_we_o), 64'(e.we));
      checkOutput("ownerBeat", 64'(e.isDc ? dc_beat_o : ic_beat_o), 64'(e.idx));
      checkOutput("otherBeat", 64'(e.isDc ? ic_beat_o : dc_beat_o), 64'(0));
    end
    if (dutBeat) begin
      if (expQ.size() == 0) begin
        reportFail("beatQueue");
      end else begin
        e = expQ.pop_front();
        checkOutput("icRvalid", 64'(ic_rvalid_o), 64'(!e.isDc));
        checkOutput("dcRvalid", 64'(dc_rvalid_o), 64'(e.isDc && !e.we));
        checkOutput("dcWready", 64'(dc_wready_o), 64'(e.isDc && e.we));
        if (e.we) begin
          checkOutput("memWdata", 64'(mem_wdata_o), 64'(e.data));
        end else begin
          checkOutput("rdata", 64'(e.isDc ? dc_rdata_o : ic_rdata_o), 64'(e.data));
          checkOutput("otherRdata", 64'(e.isDc ? ic_rdata_o : dc_rdata_o), 64'(0));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    ic_req_i  = 1'b0;
    ic_addr_i = '0;
    dc_req_i  = 1'b0;
    dc_we_i   = 1'b0;
    dc_addr_i = '0;
    dcSeed    = '0;
    mem_ready_i = 1'b0;
    icPending = 1'b0;
    dcPending = 1'b0;
    pIcReq    = 0;
    pDcReq    = 0;
    pReady    = 100;
    pDrop     = 0;
    repeat (3) applyStimulus();
    rst = 1'b0;
    applyStimulus();

    $display("[TB] scene: lone I-cache refill");
    raiseIc(32'h0000_1008);
    waitQuiet(20);

    $display("[TB] scene: simultaneous requests, twice");
    raiseIc(32'h0000_3004);
    raiseDc(32'h0000_4018, 1'b0);
    waitQuiet(40);
    raiseIc(32'h0000_5000);
    raiseDc(32'h0000_600C, 1'b1);
    waitQuiet(40);

    $display("[TB] scene: D-cache write-back with wait states");
    raiseDc(32'h0000_2004, 1'b1);
    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    waitQuiet(30);

    $display("[TB] scene: reset on the second beat");
    raiseIc(32'h0000_1008);
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    waitQuiet(20);

    $display("[TB] scene: request dropped after the first beat");
    raiseIc(32'h0000_7010);
    applyStimulus();
    applyStimulus();
    ic_req_i = 1'b0;
    waitQuiet(20);

    $display("[TB] scene: random traffic");
    pIcReq = 25;
    pDcReq = 25;
    pReady = 70;
    pDrop  = 3;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rst = ($urandom_range(0, 399) == 0);
    end
    rst    = 1'b0;
    pIcReq = 0;
    pDcReq = 0;
    pDrop  = 0;
    pReady = 100;
    applyStimulus();
    waitQuiet(100);
    applyStimulus();
    checkOutput("leftoverBeats", 64'(expQ.size()), 64'(0));
    checkOutput("leftoverDones", 64'(doneQ.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
